rf_write_arbiter: RTL and testbench

Shares the single write port of the 8×16-bit register file between two requesters: CPU writeback (req0) and an auxiliary loader (req1). It uses round-robin arbitration with a valid/ready handshake. It also optionally sequences a clear sweep that zeroes all eight registers after reset or on command. The block sits between the writeback/loader logic and the register file's RD/WD/we inputs; the read ports are not touched.

---
 rtl/rf_write_arbiter.sv | 116 +++++++++++
 tb/tb_rf_write_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the single write port of the 8x16 register file between CPU
// writeback (req0) and an auxiliary loader (req1). Ties between the two
// requesters are broken round-robin. An optional clear sweep zeroes every
// register after reset or when sw_clear is pulsed.
//
// Build option: define RF_CLEAR_EN to compile in the CLEAR sweep and sw_clear.
// Without it the block is permanently in RUN, sw_clear is ignored and busy is 0.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/addr/data            requester N write request (N = 0, 1)
//   reqN_ready                      combinational accept, high only for the grantee
//   sw_clear                        single-cycle pulse requesting a clear sweep
//   rf_we, rf_wa, rf_wd             registered register-file write port
//   grant_id                        source of the current rf_we cycle (0 during clear)
//   busy                            high while a clear sweep is in progress
module rf_write_arbiter #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          sw_clear,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          grant_id,
  output logic          busy
);

  logic          pri;         // index that wins when both requesters are valid
  logic          clearing_c;  // sweep owns the write port this cycle
  logic [AW-1:0] clr_idx_c;   // sweep address for this cycle
  logic          gnt_c;       // granted index
  logic          xfer_c;      // a request is accepted on the next edge

`ifdef RF_CLEAR_EN
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_idx;

  // Sweep sequencer: walks clr_idx over every register, then hands over to RUN.
  // sw_clear is only honoured in RUN, so a sweep in progress never restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      clr_idx <= clr_idx + AW'(1);
      if (&clr_idx) state <= ST_RUN;
    end else if (sw_clear) begin
      state <= ST_CLEAR;
    end
  end

  assign clearing_c = (state == ST_CLEAR);
  assign clr_idx_c  = clr_idx;
  assign busy       = clearing_c;
`else
  logic unused_sw_clear;

  assign unused_sw_clear = sw_clear;
  assign clearing_c      = 1'b0;
  assign clr_idx_c       = '0;
  assign busy            = 1'b0;
`endif

  // Grant: a lone requester wins outright; on a tie the pointer decides.
  always_comb begin
    gnt_c  = req1_valid;
    if (req0_valid && req1_valid) gnt_c = pri;
    xfer_c = !clearing_c && (req0_valid || req1_valid);
  end

  assign req0_ready = xfer_c && !gnt_c;
  assign req1_ready = xfer_c &&  gnt_c;

  // Registered write port. A transfer accepted in the same cycle as sw_clear
  // still issues here; the sweep follows on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
      grant_id <= 1'b0;
      pri      <= 1'b0;
    end else if (clearing_c) begin
      rf_we    <= 1'b1;
      rf_wa    <= clr_idx_c;
      rf_wd    <= '0;
      grant_id <= 1'b0;
    end else begin
      rf_we <= xfer_c;
      if (xfer_c) begin
        rf_wa    <= gnt_c ? req1_addr : req0_addr;
        rf_wd    <= gnt_c ? req1_data : req0_data;
        grant_id <= gnt_c;
        pri      <= !gnt_c;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: randomized and directed traffic, a reference
// model of the arbitration/clear rules, and a scoreboard monitor on the write port.
module tb_rf_write_arbiter;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 3;
  localparam int unsigned NREG = 8;

`ifdef RF_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          g;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          sw_clear = 1'b0;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic          grant_id;
  logic          busy;

  rf_write_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .sw_clear(sw_clear),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  req_t q0[$], q1[$];           // pending requests per requester, head is presented
  wr_t  exp_q[$];               // expected writes, one per accepted cycle
  logic gid_log[$];             // grant_id of every observed write
  logic [DW-1:0] rf_mem[NREG];  // register file as built from DUT writes
  logic [DW-1:0] ref_mem[NREG]; // register file as predicted by the model
  int   clear_left = 0;         // model: sweep writes still to come
  bit   tie_winner = 1'b0;      // model: who wins the next tie

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write on the port must be the oldest expected one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rf_we === 1'b1) begin
        rf_mem[rf_wa] = rf_wd;
        gid_log.push_back(grant_id);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {12'd0, rf_wa, rf_wd, grant_id}, 32'hFFFF_FFFF);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("write_addr", 32'(rf_wa), 32'(w.a));
          chk("write_data", 32'(rf_wd), 32'(w.d));
          chk("write_gid", 32'(grant_id), 32'(w.g));
        end
      end else if (exp_q.size() != 0) begin
        wr_t w;
        w = exp_q.pop_front();
        chk("missing_write", 32'(rf_we), 32'd1);
      end
    end
  end

  // One cycle, starting and ending at a falling edge: present requests,
  // predict the response, and queue the expected write.
  task automatic step(input bit clr);
    bit   v0, v1, g;
    wr_t  w;
    req_t r;
    v0 = (q0.size() != 0);
    v1 = (q1.size() != 0);
    req0_valid = v0;
    req1_valid = v1;
    if (v0) begin req0_addr = q0[0].a; req0_data = q0[0].d; end
    if (v1) begin req1_addr = q1[0].a; req1_data = q1[0].d; end
    sw_clear = clr;
    #1;
    chk("busy", 32'(busy), 32'(clear_left != 0));
    if (clear_left != 0) begin
      chk("ready_in_clear", {30'd0, req1_ready, req0_ready}, 32'd0);
      w.a = AW'(NREG - clear_left);
      w.d = '0;
      w.g = 1'b0;
      exp_q.push_back(w);
      ref_mem[w.a] = '0;
      clear_left--;
    end else begin
      g = (v0 && v1) ? tie_winner : v1;
      chk("ready_run", {30'd0, req1_ready, req0_ready},
          (v0 || v1) ? (g ? 32'd2 : 32'd1) : 32'd0);
      if (v0 || v1) begin
        r = g ? q1.pop_front() : q0.pop_front();
        w.a = r.a;
        w.d = r.d;
        w.g = g;
        exp_q.push_back(w);
        ref_mem[w.a] = w.d;
        tie_winner = !g;
      end
      if (clr && CLR_EN) clear_left = NREG;
    end
    @(posedge clk);
    @(negedge clk);
    sw_clear = 1'b0;
  endtask

  // Assert reset mid-cycle, check outputs drop at once, release on a falling edge.
  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sw_clear   = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_wa", 32'(rf_wa), 32'd0);
    chk("rst_rf_wd", 32'(rf_wd), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'(CLR_EN));
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    exp_q.delete();
    q0.delete();
    q1.delete();
    tie_winner = 1'b0;
    clear_left = CLR_EN ? NREG : 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic chk_mem(input string name);
    for (int i = 0; i < NREG; i++) chk(name, 32'(rf_mem[i]), 32'(ref_mem[i]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREG; i++) begin
      rf_mem[i]  = DW'($urandom);
      ref_mem[i] = rf_mem[i];
    end
    @(negedge clk);
    do_reset();
    idle(9);                       // sweep (if built in) then a RUN cycle
    chk("rd1_after_sweep", 32'(rf_mem[5]), 32'(ref_mem[5]));
    chk("rd2_after_sweep", 32'(rf_mem[6]), 32'(ref_mem[6]));

    // Single writer.
    q0.push_back('{a: 3'd5, d: 16'd100});
    step(1'b0);
    q0.push_back('{a: 3'd6, d: 16'd101});
    idle(3);
    chk("single_rd1", 32'(rf_mem[5]), 32'd100);
    chk("single_rd2", 32'(rf_mem[6]), 32'd101);

    // Contention from a fresh reset: grants alternate starting with req0.
    do_reset();
    idle(9);
    gid_log.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{a: 3'd1, d: 16'h1111});
      q1.push_back('{a: 3'd2, d: 16'h2222});
    end
    idle(10);
    chk("contention_count", 32'(gid_log.size()), 32'd8);
    for (int i = 0; i < gid_log.size() && i < 8; i++)
      chk("contention_order", 32'(gid_log[i]), 32'(i % 2));

    // Same-address race with the pointer back at req0: req1 lands last.
    q0.push_back('{a: 3'd3, d: 16'hAAAA});
    q1.push_back('{a: 3'd3, d: 16'h5555});
    idle(4);
    chk("race_reg3", 32'(rf_mem[3]), 32'h5555);

    // sw_clear while req1 is accepted; req0 arrives and must wait out the sweep.
    q1.push_back('{a: 3'd4, d: 16'h1234});
    step(1'b1);
    q0.push_back('{a: 3'd7, d: 16'hBEEF});
    idle(11);
    chk("clear_reg4", 32'(rf_mem[4]), CLR_EN ? 32'd0 : 32'h1234);
    chk("after_clear_reg7", 32'(rf_mem[7]), 32'hBEEF);

    // Reset three cycles into a sweep; the sweep restarts from address 0.
    step(1'b1);
    idle(3);
    do_reset();
    idle(10);
    chk_mem("mem_after_rst_sweep");

    // Randomized traffic with occasional clear pulses.
    for (int n = 0; n < 400; n++) begin
      if (q0.size() < 2 && $urandom_range(2, 0) == 0)
        q0.push_back('{a: AW'($urandom_range(NREG - 1, 0)), d: DW'($urandom)});
      if (q1.size() < 2 && $urandom_range(2, 0) == 0)
        q1.push_back('{a: AW'($urandom_range(NREG - 1, 0)), d: DW'($urandom)});
      step($urandom_range(49, 0) == 0);
    end
    idle(20);
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
    chk_mem("mem_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
